// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255-style PPI bus controller: FSM state encoding,
// PPI register addresses and phase-counter helpers.
package ppi_pkg;

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } ppi_state_e;

  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  // PPI_RESET stays high for this many cycles after RESET drops
  localparam int unsigned PRST_CYC = 2;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1
  function automatic logic [2:0] phase_load(input int unsigned cyc);
    return 3'(cyc - 1);
  endfunction

endpackage

// File: rtl/ppi_bus_controller.sv
// Host-command to PPI bus-cycle sequencer. Writes INIT_CW to the control
// register after reset, then runs single read/write cycles with programmable
// setup / strobe / hold lengths. The DATA tri-state buffer lives in the parent.
module ppi_bus_controller #(
  parameter logic [7:0]  INIT_CW    = 8'h80,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       PPI_RESET,
  output logic [1:0] A,
  output logic       CS,
  output logic       READ,
  output logic       WRITE,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic [7:0] DATA_IN
);
  import ppi_pkg::*;

  localparam logic [2:0] PrstLoad   = phase_load(PRST_CYC);
  localparam logic [2:0] SetupLoad  = phase_load(SETUP_CYC);
  localparam logic [2:0] StrobeLoad = phase_load(STROBE_CYC);
  localparam logic [2:0] HoldLoad   = phase_load(HOLD_CYC);

  ppi_state_e r_state, w_state_next;
  logic [2:0] r_phase, w_phase_next;
  logic       w_phase_done;
  logic       w_accept;
  logic       w_load_init;
  logic       w_busy;

  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_write;
  logic       r_is_init;
  logic       r_init_done;
  logic [7:0] r_rdata;
  logic       r_rsp_valid;

  assign w_phase_done = (r_phase == 3'd0);
  assign cmd_ready    = (r_state == IDLE) && r_init_done;
  assign w_accept     = cmd_valid && cmd_ready;

  // State and phase counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= PRST;
      r_phase <= PrstLoad;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // Next-state logic; the phase counter reloads on every state entry
  always_comb begin
    w_state_next = r_state;
    w_phase_next = w_phase_done ? 3'd0 : r_phase - 3'd1;
    w_load_init  = 1'b0;
    case (r_state)
      PRST: begin
        if (w_phase_done) begin
          w_state_next = INIT;
          w_phase_next = 3'd0;
        end
      end
      INIT: begin
        w_load_init  = 1'b1;
        w_state_next = SETUP;
        w_phase_next = SetupLoad;
      end
      IDLE: begin
        w_phase_next = 3'd0;
        if (w_accept) begin
          w_state_next = SETUP;
          w_phase_next = SetupLoad;
        end
      end
      SETUP: begin
        if (w_phase_done) begin
          w_state_next = STROBE;
          w_phase_next = StrobeLoad;
        end
      end
      STROBE: begin
        if (w_phase_done) begin
          w_state_next = HOLD;
          w_phase_next = HoldLoad;
        end
      end
      HOLD: begin
        if (w_phase_done) begin
          w_state_next = IDLE;
          w_phase_next = 3'd0;
        end
      end
      default: begin
        w_state_next = PRST;
        w_phase_next = PrstLoad;
      end
    endcase
  end

  // Command latch, read capture, response pulse and init completion flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr      <= 2'd0;
      r_wdata     <= 8'd0;
      r_write     <= 1'b0;
      r_is_init   <= 1'b0;
      r_init_done <= 1'b0;
      r_rdata     <= 8'd0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_load_init) begin
        r_addr    <= CTRL;
        r_wdata   <= INIT_CW;
        r_write   <= 1'b1;
        r_is_init <= 1'b1;
      end else if (w_accept) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_write   <= cmd_write;
        r_is_init <= 1'b0;
      end
      // Sample DATA_IN at the close of the last strobe cycle
      if ((r_state == STROBE) && w_phase_done && !r_write) begin
        r_rdata     <= DATA_IN;
        r_rsp_valid <= 1'b1;
      end
      if ((r_state == HOLD) && w_phase_done && r_is_init) begin
        r_init_done <= 1'b1;
        r_is_init   <= 1'b0;
      end
    end
  end

  // PPI bus outputs decoded from the registered state
  always_comb begin
    w_busy    = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
    PPI_RESET = (r_state == PRST);
    CS        = !w_busy;
    A         = w_busy ? r_addr : 2'd0;
    READ      = !((r_state == STROBE) && !r_write);
    WRITE     = !((r_state == STROBE) && r_write);
    DATA_OE   = w_busy && r_write;
    DATA_OUT  = (w_busy && r_write) ? r_wdata : 8'd0;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_ppi_bus_controller.sv
// Directed bench for ppi_bus_controller. Three instances: A (defaults),
// B (INIT_CW = 8'h9B) sharing A's host inputs, and C (3/1/2 phase timing).
module tb_ppi_bus_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Host side shared by A and B
  logic       valid_ab = 1'b0, write_ab = 1'b0;
  logic [1:0] addr_ab  = 2'd0;
  logic [7:0] wdata_ab = 8'd0, din_ab = 8'd0;
  // Host side for C
  logic       valid_c = 1'b0, write_c = 1'b0;
  logic [1:0] addr_c  = 2'd0;
  logic [7:0] wdata_c = 8'd0, din_c = 8'd0;

  logic       ready_a, rspv_a, done_a, pr_a, cs_a, rd_a, wr_a, oe_a;
  logic [7:0] rdata_a, dout_a;
  logic [1:0] a_a;
  logic       ready_b, rspv_b, done_b, pr_b, cs_b, rd_b, wr_b, oe_b;
  logic [7:0] rdata_b, dout_b;
  logic [1:0] a_b;
  logic       ready_c, rspv_c, done_c, pr_c, cs_c, rd_c, wr_c, oe_c;
  logic [7:0] rdata_c, dout_c;
  logic [1:0] a_c;

  ppi_bus_controller u_dut_a (
    .CLK(clk), .RESET(rst), .cmd_valid(valid_ab), .cmd_ready(ready_a),
    .cmd_write(write_ab), .cmd_addr(addr_ab), .cmd_wdata(wdata_ab),
    .rsp_valid(rspv_a), .rsp_rdata(rdata_a), .init_done(done_a), .PPI_RESET(pr_a),
    .A(a_a), .CS(cs_a), .READ(rd_a), .WRITE(wr_a), .DATA_OUT(dout_a), .DATA_OE(oe_a),
    .DATA_IN(din_ab)
  );

  ppi_bus_controller #(.INIT_CW(8'h9B)) u_dut_b (
    .CLK(clk), .RESET(rst), .cmd_valid(valid_ab), .cmd_ready(ready_b),
    .cmd_write(write_ab), .cmd_addr(addr_ab), .cmd_wdata(wdata_ab),
    .rsp_valid(rspv_b), .rsp_rdata(rdata_b), .init_done(done_b), .PPI_RESET(pr_b),
    .A(a_b), .CS(cs_b), .READ(rd_b), .WRITE(wr_b), .DATA_OUT(dout_b), .DATA_OE(oe_b),
    .DATA_IN(din_ab)
  );

  ppi_bus_controller #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut_c (
    .CLK(clk), .RESET(rst), .cmd_valid(valid_c), .cmd_ready(ready_c),
    .cmd_write(write_c), .cmd_addr(addr_c), .cmd_wdata(wdata_c),
    .rsp_valid(rspv_c), .rsp_rdata(rdata_c), .init_done(done_c), .PPI_RESET(pr_c),
    .A(a_c), .CS(cs_c), .READ(rd_c), .WRITE(wr_c), .DATA_OUT(dout_c), .DATA_OE(oe_c),
    .DATA_IN(din_c)
  );

  // {PPI_RESET, CS, READ, WRITE, A[1:0], DATA_OE, init_done}
  logic [7:0] vec_a, vec_b;
  // {CS, WRITE, READ, DATA_OE, cmd_ready}
  logic [4:0] vec_c;
  assign vec_a = {pr_a, cs_a, rd_a, wr_a, a_a, oe_a, done_a};
  assign vec_b = {pr_b, cs_b, rd_b, wr_b, a_b, oe_b, done_b};
  assign vec_c = {cs_c, wr_c, rd_c, oe_c, ready_c};

  // Minimal PPI register model: latches the bus on the rising edge of WRITE
  logic [7:0] ppi_a [4];
  logic [7:0] ppi_b [4];
  logic [7:0] ppi_c [4];
  always @(posedge wr_a) if (!rst) ppi_a[a_a] <= dout_a;
  always @(posedge wr_b) if (!rst) ppi_b[a_b] <= dout_b;
  always @(posedge wr_c) if (!rst) ppi_c[a_c] <= dout_c;

  int overlap = 0;
  always @(negedge clk) begin
    if ((!rd_a && !wr_a) || (!rd_b && !wr_b) || (!rd_c && !wr_c)) overlap <= overlap + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock, then check both A and B bus vectors, data and response pulse
  task automatic cyc(input string tag, input logic [7:0] ev, input logic [7:0] edo_a,
                     input logic [7:0] edo_b, input logic erv);
    tick();
    check({tag, " vec_a"}, vec_a, ev);
    check({tag, " vec_b"}, vec_b, ev);
    check({tag, " dout_a"}, dout_a, edo_a);
    check({tag, " dout_b"}, dout_b, edo_b);
    check({tag, " rspv_a"}, 8'(rspv_a), 8'(erv));
    check({tag, " rspv_b"}, 8'(rspv_b), 8'(erv));
  endtask

  // Starts with RESET just released; runs to the first ready IDLE cycle
  task automatic init_seq(input string tag);
    cyc({tag, " prst"},   8'b1111_0000, 8'h00, 8'h00, 1'b0);
    cyc({tag, " init"},   8'b0111_0000, 8'h00, 8'h00, 1'b0);
    cyc({tag, " setup"},  8'b0011_1110, 8'h80, 8'h9B, 1'b0);
    cyc({tag, " strb1"},  8'b0010_1110, 8'h80, 8'h9B, 1'b0);
    cyc({tag, " strb2"},  8'b0010_1110, 8'h80, 8'h9B, 1'b0);
    cyc({tag, " hold"},   8'b0011_1110, 8'h80, 8'h9B, 1'b0);
    cyc({tag, " idle"},   8'b0111_0001, 8'h00, 8'h00, 1'b0);
    check({tag, " ready"}, 8'(ready_a), 8'd1);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!ready_a && n < 20) begin
      tick();
      n++;
    end
    check({tag, " ready"}, 8'(ready_a), 8'd1);
    check({tag, " cs_idle"}, 8'(cs_a), 8'd1);
  endtask

  int  n;
  bit  seen;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst vec", vec_a, 8'b1111_0000);
    check("rst dout", dout_a, 8'h00);
    check("rst ready", 8'(ready_a), 8'd0);
    check("rst rspv", 8'(rspv_a), 8'd0);
    check("rst rdata", rdata_a, 8'h00);

    // Release: PRST x2, init write of the control word
    rst = 1'b0;
    init_seq("boot");
    check("boot ctrl_a", ppi_a[3], 8'h80);
    check("boot ctrl_b", ppi_b[3], 8'h9B);

    // Write 8'h90 to port A
    valid_ab = 1'b1; write_ab = 1'b1; addr_ab = 2'd0; wdata_ab = 8'h90;
    cyc("wr setup", 8'b0011_0011, 8'h90, 8'h90, 1'b0);
    valid_ab = 1'b0;
    cyc("wr strb1", 8'b0010_0011, 8'h90, 8'h90, 1'b0);
    cyc("wr strb2", 8'b0010_0011, 8'h90, 8'h90, 1'b0);
    cyc("wr hold",  8'b0011_0011, 8'h90, 8'h90, 1'b0);
    cyc("wr idle",  8'b0111_0001, 8'h00, 8'h00, 1'b0);
    check("wr porta", ppi_a[0], 8'h90);

    // Read port B; only the value present in the last strobe cycle counts
    valid_ab = 1'b1; write_ab = 1'b0; addr_ab = 2'd1; din_ab = 8'h11;
    cyc("rd setup", 8'b0011_0101, 8'h00, 8'h00, 1'b0);
    valid_ab = 1'b0;
    cyc("rd strb1", 8'b0001_0101, 8'h00, 8'h00, 1'b0);
    cyc("rd strb2", 8'b0001_0101, 8'h00, 8'h00, 1'b0);
    din_ab = 8'h6E;
    cyc("rd hold",  8'b0011_0101, 8'h00, 8'h00, 1'b1);
    check("rd rdata_b", rdata_b, 8'h6E);
    din_ab = 8'hFF;
    cyc("rd idle",  8'b0111_0001, 8'h00, 8'h00, 1'b0);
    check("rd hold_a", rdata_a, 8'h6E);
    check("rd hold_b", rdata_b, 8'h6E);

    // Back-to-back: write ctrl 8'h07 then read port C, both held valid
    valid_ab = 1'b1; write_ab = 1'b1; addr_ab = 2'd3; wdata_ab = 8'h07;
    wait_ready("b2b first", n);
    tick();
    write_ab = 1'b0; addr_ab = 2'd2; din_ab = 8'hC3;
    check("b2b busy", 8'(ready_a), 8'd0);
    wait_ready("b2b second", n);
    check("b2b latency", 8'(n + 1), 8'd5);
    tick();
    valid_ab = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = rspv_a;
    end
    check("b2b rsp_seen", 8'(seen), 8'd1);
    check("b2b rdata", rdata_a, 8'hC3);
    check("b2b ctrl", ppi_a[3], 8'h07);
    wait_ready("b2b end", n);

    // Reset during the strobe of a read
    valid_ab = 1'b1; write_ab = 1'b0; addr_ab = 2'd2; din_ab = 8'h5C;
    tick();
    valid_ab = 1'b0;
    tick();
    check("abort in_strobe", 8'(rd_a), 8'd0);
    rst = 1'b1;
    tick();
    check("abort vec", vec_a, 8'b1111_0000);
    check("abort rspv", 8'(rspv_a), 8'd0);
    check("abort rdata", rdata_a, 8'h00);
    check("abort ready", 8'(ready_a), 8'd0);
    rst = 1'b0;
    init_seq("reinit");

    // Instance C: 3/1/2 phases, ready 7 cycles after acceptance
    for (int i = 0; i < 30 && !done_c; i++) tick();
    check("c init_done", 8'(done_c), 8'd1);
    check("c ctrl", ppi_c[3], 8'h80);
    valid_c = 1'b1; write_c = 1'b1; addr_c = 2'd2; wdata_c = 8'h5A;
    check("c ready", 8'(ready_c), 8'd1);
    for (int i = 1; i <= 7; i++) begin
      logic [4:0] ev;
      tick();
      valid_c = 1'b0;
      ev = (i <= 3) ? 5'b01110 : (i == 4) ? 5'b00110 : (i <= 6) ? 5'b01110 : 5'b11101;
      check($sformatf("c cyc%0d vec", i), 8'(vec_c), 8'(ev));
      check($sformatf("c cyc%0d dout", i), dout_c, (i <= 6) ? 8'h5A : 8'h00);
    end
    check("c portc", ppi_c[2], 8'h5A);

    check("no overlap", 8'(overlap), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
